// File: rtl/branch_predict_btb.sv
// Direct-mapped branch target buffer with saturating direction counters.
// IF reads the table combinationally; EX resolves, trains the table and reports redirects.
module branch_predict_btb #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 4,
    parameter int CTR_W  = 2,
    parameter int STAT_W = 16
) (
    input  logic              sysclk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              if_hit,
    output logic              if_pred_taken,
    output logic [ADDR_W-1:0] if_pred_target,
    input  logic              if_stall,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    input  logic [ADDR_W-1:0] ex_pc_plus4,
    output logic              ex_mispredict,
    output logic [ADDR_W-1:0] ex_redirect_pc,
    input  logic              clear,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic              valid_mem  [DEPTH];
    logic [TAG_W-1:0]  tag_mem    [DEPTH];
    logic [ADDR_W-1:0] target_mem [DEPTH];
    logic [CTR_W-1:0]  ctr_mem    [DEPTH];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] if_tag;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic [CTR_W-1:0] ctr_next;
    logic             unused_pc_bits;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[ADDR_W-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[ADDR_W-1:IDX_W+2];
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    // Lookup reads registered state only, so a same-cycle update is not visible here.
    always_comb begin
        if_hit         = valid_mem[if_idx] && (tag_mem[if_idx] == if_tag);
        if_pred_taken  = if_hit && ctr_mem[if_idx][CTR_W-1];
        if_pred_target = if_hit ? target_mem[if_idx] : '0;
    end

    assign ex_hit         = valid_mem[ex_idx] && (tag_mem[ex_idx] == ex_tag);
    assign ex_mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                                         (ex_taken && (ex_target != ex_pred_target)));
    assign ex_redirect_pc = ex_taken ? ex_target : ex_pc_plus4;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ctr_next = ctr_mem[ex_idx];
        if (ex_taken) begin
            if (ctr_next != CTR_MAX) ctr_next = ctr_next + CTR_W'(1);
        end else if (ctr_next != '0) begin
            ctr_next = ctr_next - CTR_W'(1);
        end
    end

    // NOTE: the table is reset entry by entry because lookups must read defined values straight out of reset.
    // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
    always_ff @(posedge sysclk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_mem[i]  <= 1'b0;
                tag_mem[i]    <= '0;
                target_mem[i] <= '0;
                ctr_mem[i]    <= CTR_INIT;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) valid_mem[i] <= 1'b0;
        end else if (ex_valid) begin
            if (ex_hit) begin
                ctr_mem[ex_idx] <= ctr_next;
                if (ex_taken) target_mem[ex_idx] <= ex_target;
            end else if (ex_taken) begin
                valid_mem[ex_idx]  <= 1'b1;
                tag_mem[ex_idx]    <= ex_tag;
                target_mem[ex_idx] <= ex_target;
                ctr_mem[ex_idx]    <= CTR_INIT;
            end
        end
    end

    // Statistics survive clear; only Reset_n zeroes them.
    always_ff @(posedge sysclk or negedge Reset_n) begin
        if (!Reset_n) begin
            stat_hits    <= '0;
            stat_mispred <= '0;
        end else begin
            if (if_hit && !if_stall && (stat_hits != STAT_MAX))
                stat_hits <= stat_hits + STAT_W'(1);
            if (ex_mispredict && (stat_mispred != STAT_MAX))
                stat_mispred <= stat_mispred + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_btb.sv
// Scoreboard bench for branch_predict_btb: a driver pushes model predictions, a monitor pops and compares.
// The reference model is an array of plain records indexed by arithmetic on the PC.
module tb_branch_predict_btb;

    localparam int ADDR_W = 32;
    localparam int IDX_W  = 4;
    localparam int CTR_W  = 2;
    localparam int STAT_W = 8;
    localparam int DEPTH  = 2 ** IDX_W;
    localparam int CTR_TOP  = (2 ** CTR_W) - 1;
    localparam int CTR_HALF = 2 ** (CTR_W - 1);
    localparam int STAT_TOP = (2 ** STAT_W) - 1;

    logic              sysclk = 1'b0;
    logic              Reset_n;
    logic [ADDR_W-1:0] if_pc;
    logic              if_hit;
    logic              if_pred_taken;
    logic [ADDR_W-1:0] if_pred_target;
    logic              if_stall;
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_pc;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_target;
    logic              ex_pred_taken;
    logic [ADDR_W-1:0] ex_pred_target;
    logic [ADDR_W-1:0] ex_pc_plus4;
    logic              ex_mispredict;
    logic [ADDR_W-1:0] ex_redirect_pc;
    logic              clear;
    logic [STAT_W-1:0] stat_hits;
    logic [STAT_W-1:0] stat_mispred;

    branch_predict_btb #(
        .ADDR_W(ADDR_W), .IDX_W(IDX_W), .CTR_W(CTR_W), .STAT_W(STAT_W)
    ) dut (
        .sysclk(sysclk), .Reset_n(Reset_n),
        .if_pc(if_pc), .if_hit(if_hit), .if_pred_taken(if_pred_taken),
        .if_pred_target(if_pred_target), .if_stall(if_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_pc_plus4(ex_pc_plus4), .ex_mispredict(ex_mispredict),
        .ex_redirect_pc(ex_redirect_pc), .clear(clear),
        .stat_hits(stat_hits), .stat_mispred(stat_mispred)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        bit          rst_n;
        logic [31:0] if_pc;
        bit          if_stall;
        bit          ex_valid;
        logic [31:0] ex_pc;
        bit          ex_taken;
        logic [31:0] ex_target;
        bit          ex_pred_taken;
        logic [31:0] ex_pred_target;
        logic [31:0] ex_pc_plus4;
        bit          clear;
    } stim_t;

    typedef struct {
        string       name;
        bit          hit;
        bit          ptaken;
        logic [31:0] ptarget;
        bit          mis;
        logic [31:0] redirect;
        int          hits;
        int          mispred;
    } exp_t;

    typedef struct {
        bit          valid;
        int unsigned hi;
        logic [31:0] target;
        int          ctr;
    } entry_t;

    entry_t model [DEPTH];
    int     m_hits;
    int     m_mis;
    exp_t   exp_q [$];
    int     checks = 0;
    int     errors = 0;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % DEPTH;
    endfunction

    function automatic int unsigned hi_of(input logic [31:0] pc);
        return pc / (4 * DEPTH);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return model[idx_of(pc)].valid && (model[idx_of(pc)].hi == hi_of(pc));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            model[i].valid  = 1'b0;
            model[i].hi     = 0;
            model[i].target = '0;
            model[i].ctr    = CTR_HALF;
        end
        m_hits = 0;
        m_mis  = 0;
    endtask

    function automatic stim_t idle(input logic [31:0] pc);
        stim_t s;
        s.rst_n = 1'b1;          s.if_pc = pc;           s.if_stall = 1'b0;
        s.ex_valid = 1'b0;       s.ex_pc = pc;           s.ex_taken = 1'b0;
        s.ex_target = '0;        s.ex_pred_taken = 1'b0; s.ex_pred_target = '0;
        s.ex_pc_plus4 = pc + 4;  s.clear = 1'b0;
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    // Apply one cycle of stimulus, predict the visible outputs, then advance the model across the edge.
    task automatic step(input stim_t s, input string name);
        exp_t        e;
        int unsigned i;
        int unsigned k;
        Reset_n = s.rst_n;         if_pc = s.if_pc;         if_stall = s.if_stall;
        ex_valid = s.ex_valid;     ex_pc = s.ex_pc;         ex_taken = s.ex_taken;
        ex_target = s.ex_target;   ex_pred_taken = s.ex_pred_taken;
        ex_pred_target = s.ex_pred_target;                  ex_pc_plus4 = s.ex_pc_plus4;
        clear = s.clear;
        if (!s.rst_n) model_reset();
        i = idx_of(s.if_pc);
        e.name     = name;
        e.hit      = model_hit(s.if_pc);
        e.ptaken   = e.hit && (model[i].ctr >= CTR_HALF);
        e.ptarget  = e.hit ? model[i].target : 32'h0;
        e.mis      = s.ex_valid && ((s.ex_taken != s.ex_pred_taken) ||
                                    (s.ex_taken && (s.ex_target != s.ex_pred_target)));
        e.redirect = s.ex_taken ? s.ex_target : s.ex_pc_plus4;
        e.hits     = m_hits;
        e.mispred  = m_mis;
        exp_q.push_back(e);
        if (s.rst_n) begin
            if (e.hit && !s.if_stall && m_hits < STAT_TOP) m_hits++;
            if (e.mis && m_mis < STAT_TOP) m_mis++;
            k = idx_of(s.ex_pc);
            if (s.clear) begin
                for (int j = 0; j < DEPTH; j++) model[j].valid = 1'b0;
            end else if (s.ex_valid) begin
                if (model_hit(s.ex_pc)) begin
                    if (s.ex_taken) begin
                        if (model[k].ctr < CTR_TOP) model[k].ctr++;
                        model[k].target = s.ex_target;
                    end else if (model[k].ctr > 0) begin
                        model[k].ctr--;
                    end
                end else if (s.ex_taken) begin
                    model[k].valid  = 1'b1;
                    model[k].hi     = hi_of(s.ex_pc);
                    model[k].target = s.ex_target;
                    model[k].ctr    = CTR_HALF;
                end
            end
        end
        @(posedge sysclk);
        #1;
    endtask

    task automatic branch(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                          input bit ptaken, input logic [31:0] ptgt, input string name);
        stim_t s;
        s = idle(pc);
        s.ex_valid = 1'b1; s.ex_taken = taken; s.ex_target = tgt;
        s.ex_pred_taken = ptaken; s.ex_pred_target = ptgt;
        step(s, name);
    endtask

    always @(negedge sysclk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".if_hit"},         64'(if_hit),         64'(e.hit));
            check({e.name, ".if_pred_taken"},  64'(if_pred_taken),  64'(e.ptaken));
            check({e.name, ".if_pred_target"}, 64'(if_pred_target), 64'(e.ptarget));
            check({e.name, ".ex_mispredict"},  64'(ex_mispredict),  64'(e.mis));
            check({e.name, ".ex_redirect_pc"}, 64'(ex_redirect_pc), 64'(e.redirect));
            check({e.name, ".stat_hits"},      64'(stat_hits),      64'(e.hits));
            check({e.name, ".stat_mispred"},   64'(stat_mispred),   64'(e.mispred));
        end
    end

    initial begin
        stim_t s;
        int    waited;
        Reset_n = 1'b0; if_pc = '0; if_stall = 1'b0; ex_valid = 1'b0; ex_pc = '0;
        ex_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
        ex_pc_plus4 = '0; clear = 1'b0;
        model_reset();
        @(posedge sysclk);
        #1;

        s = idle(32'h0040_0010); s.rst_n = 1'b0;
        step(s, "reset");
        branch(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0, "alloc");
        step(idle(32'h0040_0010), "alloc_hit");

        for (int n = 0; n < 3; n++)
            branch(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100, "sat_taken");
        step(idle(32'h0040_0010), "sat_top");
        for (int n = 0; n < 4; n++) begin
            branch(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100, "sat_not_taken");
            step(idle(32'h0040_0010), "sat_observe");
        end

        s = idle(32'h0040_0010); s.ex_pc = 32'h0040_0010; s.ex_valid = 1'b1;
        s.ex_pred_taken = 1'b1; s.ex_pred_target = 32'h0040_0100;
        s.ex_pc_plus4 = 32'h0040_0014;
        step(s, "mispredict");
        s.ex_valid = 1'b0;
        step(s, "no_valid");

        branch(32'h0040_0050, 1'b1, 32'h0040_0200, 1'b0, 32'h0, "alias_alloc");
        step(idle(32'h0040_0010), "alias_miss");
        step(idle(32'h0040_0050), "alias_hit");
        s = idle(32'h0040_0050); s.ex_valid = 1'b1; s.ex_pc = 32'h0040_0090;
        s.ex_taken = 1'b1; s.ex_target = 32'h0040_0300; s.clear = 1'b1;
        step(s, "clear_with_update");
        step(idle(32'h0040_0090), "clear_no_alloc");
        step(idle(32'h0040_0050), "clear_invalid");

        branch(32'h0040_0030, 1'b1, 32'h0040_0400, 1'b1, 32'h0040_0400, "same_idx_alloc");
        s = idle(32'h0040_0030); s.ex_valid = 1'b1; s.ex_pc = 32'h0040_0070;
        s.ex_taken = 1'b1; s.ex_target = 32'h0040_0500;
        step(s, "same_idx_old");
        step(idle(32'h0040_0070), "same_idx_new");
        s = idle(32'h0040_0070); s.rst_n = 1'b0;
        step(s, "mid_reset");
        step(idle(32'h0040_0070), "after_reset");

        // Small PC pool so hits, aliasing and counter saturation all recur.
        for (int n = 0; n < 700; n++) begin
            s = idle(32'h0040_0000 | ($urandom_range(0, 7) << 2) | ($urandom_range(0, 2) << 6));
            s.ex_pc = 32'h0040_0000 | ($urandom_range(0, 7) << 2) | ($urandom_range(0, 2) << 6);
            if ($urandom_range(0, 1) == 1) s.if_pc = s.ex_pc;
            s.if_stall    = ($urandom_range(0, 3) == 0);
            s.ex_valid    = ($urandom_range(0, 9) < 7);
            s.ex_taken    = $urandom_range(0, 1);
            s.ex_target   = 32'h0040_0000 | ($urandom_range(0, 15) << 4);
            s.ex_pc_plus4 = s.ex_pc + 4;
            if ($urandom_range(0, 1) == 1) begin
                s.ex_pred_taken  = model_hit(s.ex_pc) && (model[idx_of(s.ex_pc)].ctr >= CTR_HALF);
                s.ex_pred_target = model_hit(s.ex_pc) ? model[idx_of(s.ex_pc)].target : 32'h0;
            end else begin
                s.ex_pred_taken  = $urandom_range(0, 1);
                s.ex_pred_target = 32'h0040_0000 | ($urandom_range(0, 15) << 4);
            end
            s.clear = ($urandom_range(0, 59) == 0);
            step(s, "random");
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 5) begin
            @(posedge sysclk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
